// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - counter wrap/match event monitor with event FIFO
// Tracks an upstream count stream, records wrap and compare-match events into a small FIFO.
module count_event_monitor #(
  parameter int CNT_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             cmp_en,
  output logic [15:0]      evt_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       wrap_cnt,
  output logic [2:0]       fifo_level,
  output logic             overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   prev_cnt_q, prev_cnt_d;
  logic [7:0]         wrap_cnt_q, wrap_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        mem_q [FIFO_DEPTH];

  logic               wrap_evt, match_evt, push_req, push_ok, pop, full;
  logic [15:0]        rec;

  always_comb begin
    wrap_evt   = (state_q == TRACK) && cnt_vld && (cnt_in < prev_cnt_q);
    match_evt  = cmp_en && cnt_vld && (cnt_in == cmp_val) &&
                 ((state_q == IDLE) || (cnt_in != prev_cnt_q));
    state_d    = state_q;
    prev_cnt_d = prev_cnt_q;
    if (cnt_vld) begin
      state_d    = TRACK;
      prev_cnt_d = cnt_in;
    end
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_evt && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_d = wrap_cnt_q + 8'd1;
    end
    // Snapshot carries the post-increment wrap count of the same cycle.
    rec        = {match_evt, wrap_evt, wrap_cnt_d, 6'(cnt_in)};
    push_req   = wrap_evt || match_evt;
    full       = (level_q == FULL_LVL);
    pop        = evt_valid && evt_ready;
    push_ok    = push_req && (!full || pop);
    overflow_d = overflow_q || (push_req && full && !pop);
    level_d    = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_cnt_q <= '0;
      wrap_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_cnt_q <= prev_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; the output mux masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= rec;
    end
  end

  assign evt_valid  = (level_q != '0);
  assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign wrap_cnt   = wrap_cnt_q;
  assign fifo_level = 3'(level_q);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - directed self-checking bench for count_event_monitor
module tb_count_event_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cnt_in;
  logic        cnt_vld;
  logic [5:0]  cmp_val;
  logic        cmp_en;
  logic [15:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  wrap_cnt;
  logic [2:0]  fifo_level;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  count_event_monitor #(.CNT_W(6), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_vld    (cnt_vld),
    .cmp_val    (cmp_val),
    .cmp_en     (cmp_en),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .wrap_cnt   (wrap_cnt),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Inputs change right after a falling edge; outputs are read at the next falling edge.
  task automatic do_reset();
    rst     = 1'b1;
    cnt_vld = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
  endtask

  task automatic sample(input logic [5:0] v);
    cnt_in  = v;
    cnt_vld = 1'b1;
    @(negedge clk);
    cnt_vld = 1'b0;
  endtask

  task automatic test_reset();
    evt_ready = 1'b0;
    cmp_en    = 1'b0;
    cmp_val   = 6'd0;
    cnt_in    = 6'd0;
    do_reset();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    total++; if (evt_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", evt_data); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (wrap_cnt !== 8'd0) begin bad++; $display("FAIL reset_wrap got=%0d exp=0", wrap_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_no_event();
    logic [5:0] vals [3];
    vals = '{6'd5, 6'd6, 6'd7};
    do_reset();
    cmp_en = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(vals[i]);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL noevt_valid[%0d] got=%b exp=0", i, evt_valid); end
    end
    total++; if (wrap_cnt !== 8'd0) begin bad++; $display("FAIL noevt_wrap got=%0d exp=0", wrap_cnt); end
  endtask

  task automatic test_wrap();
    sample(6'd62);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL wrap_62 got=%b exp=0", evt_valid); end
    sample(6'd63);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL wrap_63 got=%b exp=0", evt_valid); end
    sample(6'd0);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", evt_valid); end
    total++; if (evt_data !== 16'h4040) begin bad++; $display("FAIL wrap_data got=%h exp=4040", evt_data); end
    total++; if (wrap_cnt !== 8'd1) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", wrap_cnt); end
    @(negedge clk);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL wrap_single got=%b exp=0", evt_valid); end
  endtask

  task automatic test_match();
    logic [5:0] vals [4];
    vals = '{6'd20, 6'd21, 6'd21, 6'd22};
    do_reset();
    evt_ready = 1'b0;
    cmp_en = 1'b1;
    cmp_val = 6'd21;
    for (int i = 0; i < 4; i++) sample(vals[i]);
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL match_level got=%0d exp=1", fifo_level); end
    total++; if (evt_data !== 16'h8015) begin bad++; $display("FAIL match_data got=%h exp=8015", evt_data); end
    evt_ready = 1'b1;
    @(negedge clk);
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL match_pop got=%0d exp=0", fifo_level); end
    cmp_en = 1'b0;
  endtask

  task automatic test_both();
    do_reset();
    evt_ready = 1'b0;
    cmp_en = 1'b1;
    cmp_val = 6'd0;
    sample(6'd63);
    sample(6'd0);
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL both_level got=%0d exp=1", fifo_level); end
    total++; if (evt_data !== 16'hC040) begin bad++; $display("FAIL both_data got=%h exp=c040", evt_data); end
    cmp_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] exp;
    do_reset();
    evt_ready = 1'b0;
    cmp_en = 1'b0;
    sample(6'd10);
    for (int k = 0; k < 5; k++) begin
      sample(6'd0);
      sample(6'd10);
    end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (wrap_cnt !== 8'd5) begin bad++; $display("FAIL ovf_wrap got=%0d exp=5", wrap_cnt); end
    @(negedge clk);
    total++; if (evt_data !== 16'h4040) begin bad++; $display("FAIL ovf_hold got=%h exp=4040", evt_data); end
    evt_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp = 16'h4000 | (16'(k) << 6);
      total++; if (evt_data !== exp || evt_valid !== 1'b1) begin bad++; $display("FAIL ovf_order[%0d] got=%h v=%b exp=%h", k, evt_data, evt_valid, exp); end
      @(negedge clk);
    end
    total++; if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL ovf_drain got=%b/%0d exp=0/0", evt_valid, fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp;
    do_reset();
    evt_ready = 1'b0;
    cmp_en = 1'b0;
    sample(6'd10);
    for (int k = 0; k < 4; k++) begin
      sample(6'd0);
      if (k < 3) sample(6'd10);
    end
    total++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL full_fill got=%0d/%b exp=4/0", fifo_level, overflow); end
    cmp_en = 1'b1;
    cmp_val = 6'd33;
    evt_ready = 1'b1;
    sample(6'd33);
    cmp_en = 1'b0;
    total++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL full_pp got=%0d/%b exp=4/0", fifo_level, overflow); end
    for (int k = 2; k <= 5; k++) begin
      exp = (k == 5) ? 16'h8121 : (16'h4000 | (16'(k) << 6));
      total++; if (evt_data !== exp) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", k, evt_data, exp); end
      @(negedge clk);
    end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_saturate();
    do_reset();
    evt_ready = 1'b1;
    cmp_en = 1'b0;
    sample(6'd10);
    for (int k = 0; k < 260; k++) begin
      sample(6'd0);
      sample(6'd10);
    end
    total++; if (wrap_cnt !== 8'd255) begin bad++; $display("FAIL sat_wrap got=%0d exp=255", wrap_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sat_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    evt_ready = 1'b0;
    cmp_en = 1'b0;
    sample(6'd10);
    for (int k = 0; k < 5; k++) begin
      sample(6'd0);
      sample(6'd10);
    end
    rst = 1'b1;
    cnt_in = 6'd0;
    cnt_vld = 1'b1;
    evt_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_vld = 1'b0;
    evt_ready = 1'b0;
    total++; if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL mrst_fifo got=%b/%0d exp=0/0", evt_valid, fifo_level); end
    total++; if (overflow !== 1'b0 || wrap_cnt !== 8'd0) begin bad++; $display("FAIL mrst_flags got=%b/%0d exp=0/0", overflow, wrap_cnt); end
    sample(6'd0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mrst_first got=%b exp=0", evt_valid); end
    sample(6'd5);
    sample(6'd1);
    total++; if (evt_data !== 16'h4041) begin bad++; $display("FAIL mrst_wrap got=%h exp=4041", evt_data); end
  endtask

  initial begin
    rst = 1'b1;
    cnt_vld = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_event();
    test_wrap();
    test_match();
    test_both();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
